// File: rtl/esm_issue_scheduler.sv
// Buffer-control sequencer for the ESM core: fills free slots from fetch, triggers
// dependency analysis, then issues the independent slots round-robin to execute.
module esm_issue_scheduler #(
  parameter int unsigned Instruction_word_size = 32,
  parameter int unsigned bs                    = 16,
  parameter int unsigned DEP_LAT               = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fetch_valid,
  input  logic [Instruction_word_size-1:0] fetch_instr,
  output logic                             fetch_ready,
  output logic [Instruction_word_size-1:0] core_instr,
  output logic                             core_load,
  output logic [$clog2(bs)-1:0]            core_buffer_index,
  output logic [0:bs-1]                    core_valid_entries,
  output logic                             core_proceed,
  input  logic [0:bs-1]                    core_independent,
  output logic                             issue_valid,
  output logic [$clog2(bs)-1:0]            issue_index,
  input  logic                             issue_ready,
  output logic [$clog2(bs):0]              occupancy,
  output logic                             full,
  output logic                             empty
);

  localparam int unsigned IW = $clog2(bs);
  localparam int unsigned OW = IW + 1;
  localparam int unsigned CW = (DEP_LAT > 1) ? $clog2(DEP_LAT) : 1;

  typedef enum logic [1:0] {FILL, ANALYZE, WAIT, ISSUE} state_t;

  state_t          state;
  logic [0:bs-1]   valid;
  logic [0:bs-1]   ready_mask;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   wait_cnt;

  logic [IW-1:0]   alloc_ptr;
  logic [IW-1:0]   pick;
  logic [OW-1:0]   occ_cnt;
  logic [0:bs-1]   cap_mask;
  logic [0:bs-1]   ready_after;

  // Lowest free slot; stays 0 when the buffer is full.
  always_comb begin
    logic found;
    alloc_ptr = '0;
    found     = 1'b0;
    for (int i = 0; i < int'(bs); i++) begin
      if (!found && !valid[i]) begin
        alloc_ptr = IW'(i);
        found     = 1'b1;
      end
    end
  end

  // Round-robin pick: first ready slot at or after rr_ptr, wrapping (bs is a power of 2).
  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < int'(bs); k++) begin
      idx = rr_ptr + IW'(k);
      if (!found && ready_mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < int'(bs); i++) begin
      occ_cnt = occ_cnt + OW'(valid[i]);
    end
  end

  always_comb begin
    ready_after       = ready_mask;
    ready_after[pick] = 1'b0;
  end

  assign cap_mask           = core_independent & valid;
  assign occupancy          = occ_cnt;
  assign full               = (occ_cnt == OW'(bs));
  assign empty              = (occ_cnt == '0);
  assign fetch_ready        = (state == FILL) && !full;
  assign core_load          = fetch_valid && fetch_ready;
  assign core_instr         = fetch_instr;
  assign core_buffer_index  = alloc_ptr;
  assign core_valid_entries = valid;
  assign core_proceed       = (state == ANALYZE);
  assign issue_valid        = (state == ISSUE);
  assign issue_index        = pick;

  // Sequencer; fill-exit decision uses the registered bitmap, so a slot loaded this
  // cycle only counts toward full/empty from the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      valid      <= '0;
      ready_mask <= '0;
      rr_ptr     <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        FILL: begin
          if (core_load) valid[alloc_ptr] <= 1'b1;
          if (full || (!fetch_valid && !empty)) state <= ANALYZE;
        end
        ANALYZE: begin
          wait_cnt <= CW'(DEP_LAT - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            ready_mask <= cap_mask;
            state      <= (|cap_mask) ? ISSUE : FILL;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        ISSUE: begin
          if (issue_ready) begin
            valid[pick]      <= 1'b0;
            ready_mask[pick] <= 1'b0;
            rr_ptr           <= pick + IW'(1);
            if (!(|ready_after)) state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/esm_issue_scheduler.md
Name: esm_issue_scheduler

Overview:
Sequences the ESM core's instruction buffer. It accepts instructions from the fetch stream into free buffer slots and tracks the slot valid bitmap. It triggers dependency analysis in the core, then issues the slots flagged independent to the execution side with a valid/ready handshake, in round-robin order. It sits between fetch, the ESM core and the execute stage, and owns all of the core's buffer-control inputs.

Parameters:
Instruction_word_size, 32, instruction width
bs, 16, buffer slots; must be a power of 2 and at least 2
DEP_LAT, 2, cycles from core_proceed to core_independent being valid; must be at least 1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
fetch_valid  in  1  fetch offers fetch_instr
fetch_instr  in  Instruction_word_size  offered instruction
fetch_ready  out  1  slot available and scheduler in FILL
core_instr  out  Instruction_word_size  instruction written to core; equals fetch_instr
core_load  out  1  core write strobe; equals fetch_valid & fetch_ready
core_buffer_index  out  $clog2(bs)  target slot of the current write
core_valid_entries  out  [0:bs-1]  slot valid bitmap; bit i is slot i
core_proceed  out  1  one-cycle pulse that starts dependency analysis
core_independent  in  [0:bs-1]  independent-slot mask from the core
issue_valid  out  1  issue_index is offered to execute
issue_index  out  $clog2(bs)  slot being issued
issue_ready  in  1  execute accepts the issue
occupancy  out  $clog2(bs)+1  popcount of core_valid_entries
full  out  1  occupancy == bs
empty  out  1  occupancy == 0

Behaviour:
- Reset (async): state=FILL; valid bitmap=0; ready_mask=0; rr_ptr=0; wait counter=0. All outputs: fetch_ready=1, core_load=0, core_proceed=0, issue_valid=0, issue_index=0, occupancy=0, full=0, empty=1. Reset mid-operation drops all buffered and pending-issue state.
- alloc_ptr = lowest-numbered slot with valid=0. It drives core_buffer_index in every state and is 0 when full.
- FILL:
  - fetch_ready = !full.
  - On a fetch handshake, valid[alloc_ptr] is set at the next edge. core_load and core_instr are combinational, with zero latency into the core.
  - Go to ANALYZE when (full) or (!fetch_valid && !empty). These are evaluated on registered state, so the slot of the handshaking cycle is counted in the next cycle.
  - With empty and no fetch_valid, stay in FILL.
- ANALYZE: core_proceed=1 for exactly this cycle; load wait counter with DEP_LAT-1; go to WAIT. fetch_ready=0.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reads 0, capture ready_mask = core_independent & valid bitmap.
  - Next state is ISSUE if the captured mask is nonzero, otherwise FILL (no issue; fetch resumes).
- ISSUE:
  - issue_valid=1.
  - issue_index = first set bit of ready_mask scanning rr_ptr, rr_ptr+1, … with wrap modulo bs.
  - issue_index and issue_valid are held stable while issue_ready=0.
  - On issue_ready, at the edge: clear valid[issue_index] and ready_mask[issue_index]; rr_ptr = (issue_index+1) mod bs, wrapping bs-1 to 0.
  - If that clear empties ready_mask, go to FILL; otherwise stay and offer the next slot in the following cycle. One issue per cycle maximum.
- Loads occur only in FILL and clears only in ISSUE, so no same-cycle set/clear conflict exists.
- core_independent is ignored outside the capture cycle.
- occupancy, full and empty are combinational from the registered bitmap.

Test Plan:
1. Reset check: assert rst mid-ISSUE with 5 slots valid -> immediately issue_valid=0, occupancy=0, empty=1, fetch_ready=1; after release, state is FILL with rr_ptr=0.
2. Fill to full: 16 back-to-back fetch handshakes -> core_buffer_index goes 0..15; after the 16th, full=1 and fetch_ready=0. core_proceed pulses exactly one cycle later, and the capture occurs DEP_LAT=2 cycles after the pulse.
3. Partial fill and round-robin issue: load 3 instructions then drop fetch_valid -> ANALYZE. Core returns slots {0,2} independent with issue_ready=1 -> issue_index 0 then 2 on consecutive cycles; occupancy 3→2→1; return to FILL; rr_ptr=3.
4. Wrap-around: rr_ptr=14, ready_mask slots {1,15} -> issue order 15 then 1; rr_ptr ends at 2.
5. Backpressure: issue_ready=0 for 4 cycles with slot 5 pending -> issue_valid=1 and issue_index=5 held constant; valid[5] is not cleared until the accepting cycle.
6. No independent slots: core_independent all zero with occupancy 4 -> no issue_valid; returns to FILL; the next fetch is loaded into slot 4.
